mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of data-memory depth in 32-bit words.
REQ-002 SHALL have port clock  input  1  stage clock; RAM writes and FSM update on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port debugEnable  input  1  pipeline advance enable; 0 freezes stores.
REQ-005 SHALL have port debugReset  input  1  synchronous soft reset of dump FSM; blocks stores.
REQ-006 SHALL have port memRead  input  1  load request.
REQ-007 SHALL have port memWrite  input  1  store request.
REQ-008 SHALL have port memSize  input  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-009 SHALL have port memSigned  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-010 SHALL have port address  input  32  byte address (aluOut of EX/MEM).
REQ-011 SHALL have port writeData  input  32  store data, right-aligned.
REQ-012 SHALL have port memoryOut  output  32  load result, feeds MEM/WB memoryOut.
REQ-013 SHALL have port misaligned  output  1  access alignment fault flag.
REQ-014 SHALL have port dumpStart  input  1  debug request to stream RAM contents.
REQ-015 SHALL have ports dumpValid output 1, dumpIndex output DEPTH_LOG2, dumpData output 32, dumpDone output 1: debug dump stream.

Function
REQ-016 SHALL index words by address[DEPTH_LOG2+1:2]; higher address bits ignored (address wraps modulo depth).
REQ-017 SHALL use little-endian lanes: byte lane address[1:0], halfword lane address[1].
REQ-018 SHALL assert misaligned combinationally when (memRead|memWrite) and halfword with address[0]=1, or word with address[1:0]!=0.
REQ-019 SHALL write on rising clock only when memWrite=1, debugEnable=1, debugReset=0, misaligned=0; only the addressed byte lanes change.
REQ-020 SHALL produce memoryOut combinationally (zero cycle latency) from current RAM contents, so MEM/WB captures it on the following falling edge.
REQ-021 SHALL drive memoryOut=0 when memRead=0 or misaligned=1.
REQ-022 SHALL extend sub-word loads to 32 bits per memSigned.
REQ-023 SHALL, with memRead and memWrite both 1 to the same word, present pre-write data on memoryOut in that cycle; new data visible after the edge.
REQ-024 SHALL implement dump FSM states IDLE, DUMP, DONE.
REQ-025 SHALL transition IDLE->DUMP on dumpStart=1 with debugEnable=0; dumpStart with debugEnable=1 is ignored.
REQ-026 SHALL in DUMP assert dumpValid with dumpData=RAM[dumpIndex], dumpIndex counting 0..2^DEPTH_LOG2-1 one word per cycle.
REQ-027 SHALL transition DUMP->DONE after the last index, DONE->IDLE next cycle; dumpDone=1 only in DONE (one cycle).
REQ-028 SHALL ignore dumpStart while in DUMP or DONE.
REQ-029 SHALL, on debugReset=1 at any rising edge, return FSM to IDLE with dumpIndex=0; RAM contents unaffected.
REQ-030 SHALL, on a store coinciding with a dump of the same word, show pre-write data on dumpData that cycle.

Reset
REQ-031 SHALL on reset asynchronously clear all RAM words to 0, FSM to IDLE, dumpIndex to 0.
REQ-032 SHALL hold dumpValid=0, dumpDone=0, dumpData=0 during and after reset; memoryOut/misaligned follow REQ-018..021 combinationally.
REQ-033 SHALL abort an in-progress dump on reset mid-operation with no further dumpValid pulses.

Configuration
REQ-034 SHALL compile the dump FSM only when macro MEM_ACCESS_DEBUG_DUMP_EN is defined.
REQ-035 SHALL without MEM_ACCESS_DEBUG_DUMP_EN tie dumpValid, dumpIndex, dumpData, dumpDone to 0 and ignore dumpStart; load/store behaviour unchanged.

Verification
REQ-036 SHALL cover: store word 0xDEADBEEF @0x10, then load word @0x10 -> memoryOut=0xDEADBEEF.
REQ-037 SHALL cover: store byte 0x80 @0x13, load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0x80ADBEEF.
REQ-038 SHALL cover: store halfword 0x1234 @0x21 -> misaligned=1, word @0x20 stays 0, memoryOut=0.
REQ-039 SHALL cover: store word 0x55 @0x04 with debugEnable=0 -> RAM @0x04 stays 0; address 0x404 (DEPTH_LOG2=8) aliases 0x004.
REQ-040 SHALL cover: debugEnable=0, dumpStart pulse -> 256 consecutive dumpValid cycles, index 0..255, then one dumpDone; debugReset at index 5 -> IDLE, no further dumpValid.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: load/store request bundle between the EX/MEM stage and the
// data-memory block. The master drives the access; the slave returns the
// combinational load result and the alignment fault flag.
interface mem_access_if;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  memSize;
    logic        memSigned;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] memoryOut;
    logic        misaligned;

    modport master (
        output memRead, memWrite, memSize, memSigned, address, writeData,
        input  memoryOut, misaligned
    );

    modport slave (
        input  memRead, memWrite, memSize, memSigned, address, writeData,
        output memoryOut, misaligned
    );
endinterface

// File: rtl/mem_access.sv
// mem_access: MEM-stage data memory. Byte-lane stores on the rising edge and
// zero-latency loads with sign/zero extension. Words are indexed by
// address[DEPTH_LOG2+1:2], so higher address bits alias.
// Optional debug dump stream, compiled only when MEM_ACCESS_DEBUG_DUMP_EN is
// defined; without it the dump outputs are tied to 0 and dumpStart is ignored.
// dumpState exposes the dump FSM state (IDLE=0, DUMP=1, DONE=2; 0 when the
// dump logic is not built).
module mem_access #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  debugEnable,
    input  logic                  debugReset,
    mem_access_if.slave           bus,
    input  logic                  dumpStart,
    output logic                  dumpValid,
    output logic [DEPTH_LOG2-1:0] dumpIndex,
    output logic [31:0]           dumpData,
    output logic                  dumpDone,
    output logic [1:0]            dumpState
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] w_word_idx;
    logic [31:0]           w_rd_word;
    logic                  w_access;
    logic                  w_misaligned;
    logic                  w_wr_en;
    logic [3:0]            w_wr_mask;
    logic [31:0]           w_wr_data;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;

    assign w_word_idx = bus.address[DEPTH_LOG2+1:2];
    assign w_rd_word  = r_mem[w_word_idx];
    assign w_access   = bus.memRead | bus.memWrite;

    // Alignment fault: halfword on odd byte, word (size 10 or 11) off a word boundary.
    always_comb begin
        w_misaligned = 1'b0;
        if (w_access) begin
            if (bus.memSize == 2'b01)
                w_misaligned = bus.address[0];
            else if (bus.memSize[1])
                w_misaligned = (bus.address[1:0] != 2'b00);
        end
    end

    assign bus.misaligned = w_misaligned;

    // Stores only advance with the pipeline and are blocked by soft reset or a fault.
    assign w_wr_en = bus.memWrite & debugEnable & ~debugReset & ~w_misaligned;

    // Replicate right-aligned store data into every lane; the mask picks the lanes.
    always_comb begin
        w_wr_mask = 4'b0000;
        w_wr_data = bus.writeData;
        case (bus.memSize)
            2'b00: begin
                w_wr_mask = 4'b0001 << bus.address[1:0];
                w_wr_data = {4{bus.writeData[7:0]}};
            end
            2'b01: begin
                w_wr_mask = bus.address[1] ? 4'b1100 : 4'b0011;
                w_wr_data = {2{bus.writeData[15:0]}};
            end
            default: begin
                w_wr_mask = 4'b1111;
                w_wr_data = bus.writeData;
            end
        endcase
    end

    // Storage: asynchronous clear of every word, byte-lane masked stores.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (w_wr_mask[b])
                    r_mem[w_word_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
    end

    assign w_byte = w_rd_word[{bus.address[1:0], 3'b000} +: 8];
    assign w_half = bus.address[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    // Load path: lane select plus extension; reads pre-write contents during a store.
    always_comb begin
        w_load = w_rd_word;
        case (bus.memSize)
            2'b00:   w_load = bus.memSigned ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
            2'b01:   w_load = bus.memSigned ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
            default: w_load = w_rd_word;
        endcase
    end

    assign bus.memoryOut = (bus.memRead && !w_misaligned) ? w_load : 32'b0;

`ifdef MEM_ACCESS_DEBUG_DUMP_EN
    // Dump stream: dumpValid has no backpressure; while it is high one word
    // (dumpIndex, dumpData) is presented per cycle and the consumer must take
    // it that cycle. dumpDone pulses for exactly one cycle after the last word.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DUMP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [DEPTH_LOG2-1:0] w_idx_next;
    logic                  w_valid;
    logic                  w_done;
    logic                  w_unused;

    // Dump FSM register: async reset aborts any dump in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Dump FSM next state and outputs; soft reset overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_valid      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_idx_next = '0;
                if (dumpStart && !debugEnable)
                    w_state_next = S_DUMP;
            end
            S_DUMP: begin
                w_valid = 1'b1;
                if (r_idx == {DEPTH_LOG2{1'b1}}) begin
                    w_state_next = S_DONE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_idx_next   = '0;
            end
        endcase
        if (debugReset) begin
            w_state_next = S_IDLE;
            w_idx_next   = '0;
        end
    end

    assign dumpValid = w_valid;
    assign dumpDone  = w_done;
    assign dumpIndex = r_idx;
    assign dumpData  = w_valid ? r_mem[r_idx] : 32'b0;
    assign dumpState = r_state;
    assign w_unused  = &{1'b0, bus.address[31:DEPTH_LOG2+2]};
`else
    logic w_unused;

    assign dumpValid = 1'b0;
    assign dumpDone  = 1'b0;
    assign dumpIndex = '0;
    assign dumpData  = 32'b0;
    assign dumpState = 2'b00;
    assign w_unused  = &{1'b0, dumpStart, bus.address[31:DEPTH_LOG2+2]};
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access. A byte-array model predicts
// each load result and fault flag; a monitor on the falling edge pops and
// compares. Dump-stream checks are built when MEM_ACCESS_DEBUG_DUMP_EN is set.
module tb_mem_access;
    localparam int DL    = 8;
    localparam int DEPTH = 1 << DL;
    localparam int MEMB  = 4 * DEPTH;

    logic          clock = 1'b0;
    logic          reset;
    logic          debugEnable;
    logic          debugReset;
    logic          dumpStart;
    logic          dumpValid;
    logic [DL-1:0] dumpIndex;
    logic [31:0]   dumpData;
    logic          dumpDone;
    logic [1:0]    dumpState;

    mem_access_if bus ();

    mem_access #(.DEPTH_LOG2(DL)) dut (
        .clock       (clock),
        .reset       (reset),
        .debugEnable (debugEnable),
        .debugReset  (debugReset),
        .bus         (bus.slave),
        .dumpStart   (dumpStart),
        .dumpValid   (dumpValid),
        .dumpIndex   (dumpIndex),
        .dumpData    (dumpData),
        .dumpDone    (dumpDone),
        .dumpState   (dumpState)
    );

    // Clock
    always #5 clock = ~clock;

    int           checks = 0;
    int           errors = 0;
    logic [32:0]  exp_q[$];          // {misaligned, memoryOut}
    logic [DL+31:0] dump_q[$];       // {index, data}
    logic         tb_check = 1'b0;
    logic [7:0]   mem_b [MEMB];      // reference model: flat byte memory
    int           done_cnt = 0;
    int           valid_cnt = 0;
    int           cyc = 0;
    int           last_valid_cyc = -10;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < MEMB; i++) mem_b[i] = 8'h00;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge clock) begin
        logic [32:0]    e;
        logic [DL+31:0] d;
        cyc++;
        if (tb_check) begin
            if (exp_q.size() == 0) begin
                check("load_no_expect", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("misaligned", {63'b0, bus.misaligned}, {63'b0, e[32]});
                check("memoryOut", {32'b0, bus.memoryOut}, {32'b0, e[31:0]});
            end
        end
        if (dumpValid) begin
            valid_cnt++;
            if (dump_q.size() == 0) begin
                check("dump_extra_valid", 1, 0);
            end else begin
                d = dump_q.pop_front();
                check("dumpIndex", 64'(dumpIndex), 64'(d[DL+31:32]));
                check("dumpData", 64'(dumpData), 64'(d[31:0]));
                if (d[DL+31:32] != 0) check("dump_gap", 64'(cyc), 64'(last_valid_cyc + 1));
            end
            last_valid_cyc = cyc;
        end
        if (dumpDone) done_cnt++;
    end

    // Driver: one access per cycle; expectation computed from the byte model.
    task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input logic en,
                         input logic drst);
        int          n;
        int          a;
        logic        mis;
        logic [31:0] v;
        @(posedge clock); #1;
        bus.memRead   = rd;
        bus.memWrite  = wr;
        bus.memSize   = sz;
        bus.memSigned = sgn;
        bus.address   = addr;
        bus.writeData = wd;
        debugEnable   = en;
        debugReset    = drst;
        tb_check      = 1'b1;
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        a   = int'(addr % MEMB);
        mis = (rd || wr) && ((a % n) != 0);
        v   = 32'b0;
        if (rd && !mis) begin
            for (int k = 0; k < n; k++) v = v | (32'(mem_b[a+k]) << (8*k));
            if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        end
        exp_q.push_back({mis, v});
        if (wr && en && !drst && !mis)
            for (int k = 0; k < n; k++) mem_b[a+k] = wd[8*k +: 8];
    endtask

    task automatic idle();
        @(posedge clock); #1;
        tb_check      = 1'b0;
        bus.memRead   = 1'b0;
        bus.memWrite  = 1'b0;
        debugReset    = 1'b0;
    endtask

    task automatic wait_index(input int idx, input string name);
        int n = 0;
        while (!(dumpValid && int'(dumpIndex) == idx) && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
        check(name, 64'(n >= 400), 0);
    endtask

    task automatic push_dump(input int last);
        for (int i = 0; i <= last; i++)
            dump_q.push_back({DL'(i), mem_b[4*i+3], mem_b[4*i+2], mem_b[4*i+1], mem_b[4*i]});
    endtask

    initial begin
        logic [31:0] wv;
        int          n;
        reset = 1'b1; debugEnable = 1'b1; debugReset = 1'b0; dumpStart = 1'b0;
        bus.memRead = 1'b0; bus.memWrite = 1'b0; bus.memSize = 2'b10; bus.memSigned = 1'b0;
        bus.address = 32'b0; bus.writeData = 32'b0;
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        check("rst_dumpValid", 64'(dumpValid), 0);
        check("rst_dumpDone", 64'(dumpDone), 0);
        check("rst_dumpData", 64'(dumpData), 0);
        check("rst_dumpIndex", 64'(dumpIndex), 0);
        reset = 1'b0;

        // Directed scenarios
        do_op(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 0);
        do_op(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 0);
        do_op(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 0);
        do_op(0, 1, 2'b00, 0, 32'h13, 32'h80, 1, 0);
        do_op(1, 0, 2'b00, 1, 32'h13, 32'h0, 1, 0);
        do_op(1, 0, 2'b00, 0, 32'h13, 32'h0, 1, 0);
        do_op(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 0);
        do_op(0, 1, 2'b01, 0, 32'h21, 32'h1234, 1, 0);
        do_op(1, 0, 2'b10, 0, 32'h20, 32'h0, 1, 0);
        do_op(1, 0, 2'b01, 1, 32'h21, 32'h0, 1, 0);
        do_op(0, 1, 2'b10, 0, 32'h04, 32'h55, 0, 0);
        do_op(1, 0, 2'b10, 0, 32'h04, 32'h0, 1, 0);
        do_op(0, 1, 2'b10, 0, 32'h04, 32'h55, 1, 0);
        do_op(1, 0, 2'b10, 0, 32'h404, 32'h0, 1, 0);
        do_op(0, 1, 2'b10, 0, 32'h08, 32'hCAFEF00D, 1, 1);
        do_op(1, 0, 2'b11, 0, 32'h08, 32'h0, 1, 0);
        do_op(1, 1, 2'b10, 0, 32'h40, 32'h11223344, 1, 0);
        do_op(1, 0, 2'b01, 1, 32'h42, 32'h0, 1, 0);
        do_op(0, 0, 2'b10, 0, 32'h10, 32'h0, 1, 0);
        idle();

        // Randomized traffic over a 4 KiB window to exercise aliasing
        for (int i = 0; i < 400; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 4095)), $urandom,
                  1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) == 0));
        end
        idle();

`ifdef MEM_ACCESS_DEBUG_DUMP_EN
        // Full dump, with a store to the word being dumped at index 3
        @(posedge clock); #1;
        debugEnable = 1'b0; dumpStart = 1'b1;
        push_dump(DEPTH - 1);
        @(posedge clock); #1;
        dumpStart = 1'b0;
        wait_index(3, "dump_wait_idx3");
        wv = $urandom;
        bus.memWrite = 1'b1; bus.memSize = 2'b10; bus.address = 32'h0C; bus.writeData = wv;
        debugEnable = 1'b1;
        for (int k = 0; k < 4; k++) mem_b[12+k] = wv[8*k +: 8];
        @(posedge clock); #1;
        bus.memWrite = 1'b0; debugEnable = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 400) begin @(posedge clock); #1; n++; end
        check("dump_done_timeout", 64'(n >= 400), 0);
        repeat (3) @(posedge clock);
        #1;
        check("dump_done_count", 64'(done_cnt), 1);
        check("dump_valid_count", 64'(valid_cnt), 64'(DEPTH));
        check("dump_q_empty", 64'(dump_q.size()), 0);

        // Start with debugEnable high is ignored
        debugEnable = 1'b1; dumpStart = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        dumpStart = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("ignored_start_valid", 64'(valid_cnt), 64'(DEPTH));

        // Soft reset at index 5 aborts the dump
        debugEnable = 1'b0; dumpStart = 1'b1;
        push_dump(5);
        @(posedge clock); #1;
        dumpStart = 1'b0;
        wait_index(5, "dump_wait_idx5");
        debugReset = 1'b1;
        @(posedge clock); #1;
        debugReset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("soft_abort_valid", 64'(valid_cnt), 64'(DEPTH + 6));
        check("soft_abort_done", 64'(done_cnt), 1);
        check("soft_abort_index", 64'(dumpIndex), 0);

        // Async reset at index 10 aborts the dump and clears memory
        dumpStart = 1'b1;
        push_dump(9);
        @(posedge clock); #1;
        dumpStart = 1'b0;
        wait_index(10, "dump_wait_idx10");
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check("rst_abort_data", 64'(dumpData), 0);
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("rst_abort_valid", 64'(valid_cnt), 64'(DEPTH + 16));
        check("rst_abort_done", 64'(done_cnt), 1);
`else
        // Dump logic absent: outputs stay zero whatever dumpStart does
        debugEnable = 1'b0; dumpStart = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        dumpStart = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("nodump_valid", 64'(valid_cnt), 0);
        check("nodump_done", 64'(done_cnt), 0);
        check("nodump_index", 64'(dumpIndex), 0);
        check("nodump_data", 64'(dumpData), 0);
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
`endif

        // Memory reads back as cleared after reset
        do_op(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 0);
        do_op(1, 0, 2'b10, 0, 32'h0C, 32'h0, 1, 0);
        do_op(1, 0, 2'b00, 1, 32'h43, 32'h0, 1, 0);
        idle();
        repeat (2) @(posedge clock);
        #1;
        check("exp_q_empty", 64'(exp_q.size()), 0);
        check("dump_q_left", 64'(dump_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
